// File: rtl/rotr_pkg.sv
// Shared constants and types for the rotate-right arbiter slice.
// Holds data/amount widths, the requester ID type, the FSM states and the operand bundle.
package rotr_pkg;

    localparam int W     = 8;
    localparam int AMT_W = 3;

    typedef logic req_id_t;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [AMT_W-1:0] amt;
    } rotr_op_t;

endpackage

// File: rtl/rotr_core.sv
// Combinational rotate-right of a W-bit word by amt positions.
// Ports: a (operand), amt (rotate amount), y (rotated result).
module rotr_core
    import rotr_pkg::*;
(
    input  logic [W-1:0]     a,
    input  logic [AMT_W-1:0] amt,
    output logic [W-1:0]     y
);

    // Rotating right by k is the low W bits of {a,a} shifted right by k.
    logic [2*W-1:0] dbl;

    assign dbl = {a, a};

    always_comb begin
        y = a;
        unique case (amt)
            3'd0: y = dbl[0 +: W];
            3'd1: y = dbl[1 +: W];
            3'd2: y = dbl[2 +: W];
            3'd3: y = dbl[3 +: W];
            3'd4: y = dbl[4 +: W];
            3'd5: y = dbl[5 +: W];
            3'd6: y = dbl[6 +: W];
            3'd7: y = dbl[7 +: W];
            default: y = a;
        endcase
    end

endmodule

// File: rtl/rotr_arbiter.sv
// Round-robin arbiter sharing one rotate-right unit between two requesters.
// Ports: clk, reset (sync, active-high), req0/req1 valid/data/amt/ready, rsp valid/data/id/ready.
module rotr_arbiter
    import rotr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [W-1:0]     rsp_data,
    output req_id_t          rsp_id,
    input  logic             rsp_ready
);

    state_t   state;
    req_id_t  rr_ptr;
    req_id_t  sel;
    rotr_op_t op;
    logic     can_accept;
    logic     grant;
    logic     both_v;
    logic     only0_v;
    logic     only1_v;
    logic [W-1:0] rot_y;

    assign both_v  = req0_valid & req1_valid;
    assign only0_v = req0_valid & ~req1_valid;
    assign only1_v = ~req0_valid & req1_valid;

    // Nothing is accepted while reset is asserted.
    assign can_accept = ~reset & ((state == ST_EMPTY) | rsp_ready);
    assign grant      = can_accept & (req0_valid | req1_valid);

    always_comb begin
        sel = 1'b0;
        unique case (1'b1)
            both_v:  sel = rr_ptr;
            only0_v: sel = 1'b0;
            only1_v: sel = 1'b1;
            default: sel = 1'b0;
        endcase
    end

    assign req0_ready = grant & req0_valid & (sel == 1'b0);
    assign req1_ready = grant & req1_valid & (sel == 1'b1);

    always_comb begin
        op = sel ? '{data: req1_data, amt: req1_amt}
                 : '{data: req0_data, amt: req0_amt};
    end

    rotr_core u_core (
        .a   (op.data),
        .amt (op.amt),
        .y   (rot_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            rr_ptr   <= 1'b0;
        end else if (grant) begin
            state    <= ST_FULL;
            rsp_data <= rot_y;
            rsp_id   <= sel;
            rr_ptr   <= ~sel;
        end else if (state == ST_FULL && rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_rotr_arbiter.sv
// Directed testbench for rotr_arbiter.
// Table-driven cycle vectors plus hand-written amount sweep and alternation runs.
module tb_rotr_arbiter;
    import rotr_pkg::*;

    logic             clk;
    logic             reset;
    logic             req0_valid;
    logic [W-1:0]     req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_ready;
    logic             req1_valid;
    logic [W-1:0]     req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_ready;
    logic             rsp_valid;
    logic [W-1:0]     rsp_data;
    req_id_t          rsp_id;
    logic             rsp_ready;

    int n_chk;
    int n_fail;

    rotr_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic [2:0] a0;
        logic       v1;
        logic [7:0] d1;
        logic [2:0] a1;
        logic       rr;
        logic       e_r0;
        logic       e_r1;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_id;
        logic       chk_d;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        logic rst, logic v0, logic [7:0] d0, logic [2:0] a0,
        logic v1, logic [7:0] d1, logic [2:0] a1, logic rr,
        logic e_r0, logic e_r1, logic e_v, logic [7:0] e_d,
        logic e_id, logic chk_d);
        vec_t t;
        t.rst = rst; t.v0 = v0; t.d0 = d0; t.a0 = a0;
        t.v1 = v1; t.d1 = d1; t.a1 = a1; t.rr = rr;
        t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_v = e_v;
        t.e_d = e_d; t.e_id = e_id; t.chk_d = chk_d;
        return t;
    endfunction

    function automatic logic [7:0] ror_ref(logic [7:0] a, int amt);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = a[(i + amt) % 8];
        return y;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic v0, logic [7:0] d0, logic [2:0] a0,
                         logic v1, logic [7:0] d1, logic [2:0] a1, logic rr);
        reset = rst;
        req0_valid = v0; req0_data = d0; req0_amt = a0;
        req1_valid = v1; req1_data = d1; req1_amt = a1;
        rsp_ready = rr;
    endtask

    initial begin
        int exp_ptr;
        int prev_id;
        n_chk  = 0;
        n_fail = 0;
        drive(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        repeat (2) @(negedge clk);

        // rst v0 d0 a0 v1 d1 a1 rr | r0 r1 v d id chk_d
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,0,8'h00,0,1));
        vq.push_back(mk(0,1,8'hA5,1,0,8'h00,0,1, 1,0,0,8'h00,0,0));
        vq.push_back(mk(0,0,8'h00,0,1,8'h81,7,1, 0,1,1,8'hD2,0,1));
        vq.push_back(mk(0,0,8'h00,0,1,8'h01,3,1, 0,1,1,8'h03,1,1));
        vq.push_back(mk(0,0,8'h00,0,1,8'h3C,0,1, 0,1,1,8'h20,1,1));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,1,8'h3C,1,1));
        vq.push_back(mk(0,1,8'hA5,4,1,8'h0F,4,1, 1,0,0,8'h00,1,0));
        vq.push_back(mk(0,1,8'hA5,4,1,8'h0F,4,1, 0,1,1,8'h5A,0,1));
        vq.push_back(mk(0,1,8'hA5,4,1,8'h0F,4,1, 1,0,1,8'hF0,1,1));
        vq.push_back(mk(0,1,8'hA5,4,1,8'h0F,4,1, 0,1,1,8'h5A,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,1,8'hF0,1,1));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,0,8'h00,1,0));
        vq.push_back(mk(0,1,8'hA5,1,0,8'h00,0,0, 1,0,0,8'h00,1,0));
        vq.push_back(mk(0,1,8'hA5,1,1,8'h0F,4,0, 0,0,1,8'hD2,0,1));
        vq.push_back(mk(0,1,8'hA5,1,1,8'h0F,4,0, 0,0,1,8'hD2,0,1));
        vq.push_back(mk(0,1,8'hA5,1,1,8'h0F,4,0, 0,0,1,8'hD2,0,1));
        vq.push_back(mk(0,1,8'hA5,1,1,8'h0F,4,1, 0,1,1,8'hD2,0,1));
        vq.push_back(mk(0,1,8'hA5,1,1,8'h0F,4,0, 0,0,1,8'hF0,1,1));
        vq.push_back(mk(1,1,8'hA5,1,1,8'h0F,4,0, 0,0,1,8'hF0,1,1));
        vq.push_back(mk(0,1,8'hA5,1,1,8'h0F,4,1, 1,0,0,8'h00,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,1,8'hD2,0,1));
        vq.push_back(mk(0,0,8'h00,0,1,8'h0F,4,1, 0,1,0,8'h00,0,0));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,1,8'hF0,1,1));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,0,8'h00,1,0));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,0,8'h00,1,0));
        vq.push_back(mk(0,1,8'hA5,4,1,8'h0F,4,1, 1,0,0,8'h00,1,0));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,1,8'h5A,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,8'h00,0,1, 0,0,0,8'h00,0,0));

        for (int i = 0; i < vq.size(); i++) begin
            vec_t t;
            t = vq[i];
            if (i != 0) @(negedge clk);
            drive(t.rst, t.v0, t.d0, t.a0, t.v1, t.d1, t.a1, t.rr);
            #1;
            chk($sformatf("row%0d req0_ready", i), 32'(req0_ready), 32'(t.e_r0));
            chk($sformatf("row%0d req1_ready", i), 32'(req1_ready), 32'(t.e_r1));
            chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(t.e_v));
            if (t.e_v) chk($sformatf("row%0d rsp_id", i), 32'(rsp_id), 32'(t.e_id));
            if (t.chk_d) chk($sformatf("row%0d rsp_data", i), 32'(rsp_data), 32'(t.e_d));
        end

        // Sweep every rotate amount through requester 0.
        for (int amt = 0; amt < 8; amt++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 8'hB4, 3'(amt), 1'b0, 8'h00, 3'd0, 1'b1);
            #1;
            chk($sformatf("sweep%0d ready", amt), 32'(req0_ready), 32'd1);
            @(negedge clk);
            drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
            #1;
            chk($sformatf("sweep%0d valid", amt), 32'(rsp_valid), 32'd1);
            chk($sformatf("sweep%0d data", amt), 32'(rsp_data), 32'(ror_ref(8'hB4, amt)));
        end

        // Continuous contention: last grant was requester 0, so 1 goes next.
        exp_ptr = 1;
        prev_id = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 8'h12, 3'd2, 1'b1, 8'h34, 3'd6, 1'b1);
            #1;
            chk($sformatf("alt%0d req0_ready", c), 32'(req0_ready), 32'(exp_ptr == 0));
            chk($sformatf("alt%0d req1_ready", c), 32'(req1_ready), 32'(exp_ptr == 1));
            if (prev_id >= 0) begin
                chk($sformatf("alt%0d rsp_id", c), 32'(rsp_id), 32'(prev_id));
                chk($sformatf("alt%0d rsp_data", c), 32'(rsp_data),
                    32'(prev_id == 0 ? ror_ref(8'h12, 2) : ror_ref(8'h34, 6)));
            end
            prev_id = exp_ptr;
            exp_ptr = 1 - exp_ptr;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
